// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-channel arbiter that serialises byte/half/word requests onto a byte-wide memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority.
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [2*NUM_CH-1:0]      req_len,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0]     req_wdata,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [31:0]              resp_rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr
);
    localparam int         IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] LAT = 3'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              resp_q, resp_d;
    logic [IW-1:0]     own_q, own_d;

    logic              found;
    logic              grant;
    logic [IW-1:0]     win;
    logic [2:0]        cnt_inc;
    logic [2:0]        last_cnt;
    logic [1:0]        rd_idx;

    assign found = |req_valid;
    assign grant = (state_q == IDLE) && rdy_in && !rst_in && found;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ptr_q holds the channel searched first on the next grant (last winner + 1).
    logic [IW-1:0] ptr_q, ptr_d;
    logic          hi_found, lo_found;
    logic [IW-1:0] hi_win, lo_win;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_win   = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_win   = IW'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else if (rdy_in) begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = grant && (win == IW'(i));
        end
    end

    // Reads run RD_LAT cycles past the last issued byte so the final byte can land.
    assign cnt_inc  = cnt_q + 3'd1;
    assign last_cnt = we_q ? (nbytes_q - 3'd1) : (nbytes_q + LAT - 3'd1);
    assign rd_idx   = 2'(cnt_q - LAT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        nbytes_d = nbytes_q;
        cnt_d    = cnt_q;
        own_d    = own_q;
        resp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    rdata_d = '0;
                    own_d   = win;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (req_ready[i]) begin
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = req_wdata[i*32 +: 32];
                            we_d    = req_we[i];
                            case (req_len[2*i +: 2])
                                2'b00:   nbytes_d = 3'd1;
                                2'b01:   nbytes_d = 3'd2;
                                default: nbytes_d = 3'd4;
                            endcase
                        end
                    end
                end
            end
            ISSUE, WAIT: begin
                if (!we_q && (cnt_q >= LAT)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rd_idx == 2'(b)) begin
                            rdata_d[8*b +: 8] = mem_din;
                        end
                    end
                end
                if (cnt_q == last_cnt) begin
                    state_d = IDLE;
                    resp_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc < nbytes_q) ? ISSUE : WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            nbytes_q <= '0;
            cnt_q    <= '0;
            resp_q   <= 1'b0;
            own_q    <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            nbytes_q <= nbytes_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            own_q    <= own_d;
        end
    end

    // Memory outputs derive from frozen state, so a stall holds them with only mem_wr dropped.
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        if (state_q == ISSUE) begin
            mem_a  = addr_q + ADDR_W'(cnt_q);
            mem_wr = we_q && rdy_in;
            if (we_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (cnt_q[1:0] == 2'(b)) begin
                        mem_dout = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            resp_valid[i] = resp_q && rdy_in && (own_q == IW'(i));
        end
    end

    assign resp_rdata = (resp_q && rdy_in) ? rdata_q : '0;

endmodule
